dfm_measure_mc: RTL
===================

Name: dfm_measure_mc

Overview:
Multi-channel, parametrised successor to the single-channel frequency measure block of the DFM.
- Performs equal-precision (reciprocal) counting on CH_NUM asynchronous input signals simultaneously, all under one gate command.
- Per channel, produces a {signal-edge count, reference-clock count} pair.
- Writes the pairs sequentially into the register file, one channel per cycle.
- Sits between the control block (gate_st/gate_time) and the regfile write port.

Parameters:
CH_NUM, 4, number of measured signal channels (1..16)
CNT_WIDTH, 32, width of each counter; result word is 2*CNT_WIDTH
GATE_WIDTH, 8, width of gate_time_i
GATE_TICKS, 100, clk_i cycles per gate_time_i LSB

Ports:
clk_i  in  1  reference/system clock
rst_n_i  in  1  asynchronous active-low reset
sig_clk_i  in  CH_NUM  asynchronous measured signals, one bit per channel
gate_st_i  in  1  single-cycle start pulse from control
gate_time_i  in  GATE_WIDTH  preset gate length in GATE_TICKS units
busy_o  out  1  high from accepted start until last write
done_o  out  1  one-cycle pulse after last channel written
reg_wr_en_o  out  1  regfile write strobe
reg_wr_ch_o  out  clog2(CH_NUM) (min 1)  channel index of current write
reg_wr_data_o  out  2*CNT_WIDTH  {sig_cnt, ref_cnt}; sig_cnt in upper half
reg_wr_vld_o  out  1  per-write valid flag; 0 = channel timed out

Behaviour:
- Clocking and reset: one clock clk_i; reset is asynchronous and active-low (rst_n_i).
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Synchroniser: each sig_clk_i bit passes a 2-FF synchroniser plus an edge register.
  - A rising edge is a one-cycle pulse, 3 cycles after the input edge.
  - Valid for signal frequency up to clk_i/4.
- Preset: P = max(gate_time_i,1) * GATE_TICKS, latched at start. Global timer width holds 2*P.
- Top FSM: IDLE -> RUN -> DUMP -> IDLE.
  - IDLE: on gate_st_i, latch P, clear all counters, set busy_o next cycle, go to RUN. gate_st_i is ignored outside IDLE.
  - RUN: global timer counts up from 0 each cycle.
  - Channel FSM (per channel): WAIT_OPEN -> COUNT -> CLOSED.
    - WAIT_OPEN -> COUNT on the first sync edge.
    - In COUNT, from the cycle after the open edge: ref_cnt +1 per clk_i; sig_cnt +1 per edge.
    - COUNT -> CLOSED on the first edge with timer >= P. That closing edge is counted in both sig_cnt and ref_cnt.
    - Result: ref_cnt = exact integer multiple of the signal period in clk_i cycles.
  - RUN -> DUMP when all channels are CLOSED, or when timer reaches 2*P (timeout).
    - A channel not CLOSED at timeout is written with data 0 and reg_wr_vld_o=0.
    - All other writes carry reg_wr_vld_o=1.
  - DUMP: one write per cycle, channels 0..CH_NUM-1 ascending, reg_wr_en_o high for CH_NUM consecutive cycles.
    - After the last write: done_o pulses for 1 cycle, busy_o drops in the same cycle, return to IDLE.
- Saturation: each counter saturates at 2^CNT_WIDTH-1. Reaching saturation is not an error; reg_wr_vld_o stays 1.
- Edge and timer in the same cycle: an edge in the cycle where the timer first equals P closes the channel.
- Reset mid-operation: immediate abort, no partial writes, outputs return to 0.

Optional Feature:
DFM_CONT_MEAS_EN:
- Defined: adds port cont_i (in, 1).
  - When cont_i=1 at the last DUMP cycle, the FSM skips IDLE and re-enters RUN next cycle.
  - On re-entry, gate_time_i is re-latched, counters are cleared, busy_o stays high, and done_o still pulses.
- Not defined: port absent; every measurement requires a gate_st_i pulse.

Test Plan:
1. clk 5 ns, GATE_TICKS=100, gate_time=10 (P=1000), ch0 period 500 ns (100 clk) -> ch0 sig_cnt in {9,10}, ref_cnt = 100*sig_cnt, reg_wr_vld_o=1.
2. All 4 channels with periods 20/35/100/250 clk, gate_time=20 -> 4 writes on consecutive cycles, ch 0..3 in order, each ref_cnt = period*sig_cnt, done_o one pulse.
3. ch2 held static -> timeout at timer 2000 (gate_time=10); ch2 written with data 0 and vld=0, other channels valid.
4. gate_st_i re-pulsed during RUN; gate_time=0 -> extra pulses ignored, single DUMP; gate_time=0 behaves as P=100.
5. rst_n_i asserted mid-RUN -> all outputs 0 immediately, no reg_wr_en_o; the next gate_st_i measures normally.
6. DFM_CONT_MEAS_EN, cont_i=1, gate_time=5 -> back-to-back measurements with no IDLE cycle; done_o pulses each round; busy_o stays high.

Source files
------------

// File: rtl/dfm_measure_mc.sv
// rtl/dfm_measure_mc.sv - multi-channel reciprocal frequency counter with sequential regfile dump
// Optional macro DFM_CONT_MEAS_EN adds cont_i for back-to-back measurements without a new gate_st_i.
module dfm_measure_mc #(
    parameter int CH_NUM     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int GATE_WIDTH = 8,
    parameter int GATE_TICKS = 100,
    localparam int CHW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [CH_NUM-1:0]      sig_clk_i,
    input  logic                   gate_st_i,
    input  logic [GATE_WIDTH-1:0]  gate_time_i,
`ifdef DFM_CONT_MEAS_EN
    input  logic                   cont_i,
`endif
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   reg_wr_en_o,
    output logic [CHW-1:0]         reg_wr_ch_o,
    output logic [2*CNT_WIDTH-1:0] reg_wr_data_o,
    output logic                   reg_wr_vld_o
);

    localparam longint unsigned MAX_2P = 64'd2 * ((64'd1 << GATE_WIDTH) - 64'd1) * 64'(GATE_TICKS);
    localparam int TW = $clog2(MAX_2P + 64'd1);
    localparam int IW = $clog2(CH_NUM + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP} state_t;
    typedef enum logic [1:0] {C_WAIT, C_COUNT, C_CLOSED} ch_state_t;

    state_t                 state;
    ch_state_t              ch_st   [CH_NUM];
    logic [CNT_WIDTH-1:0]   sig_cnt [CH_NUM];
    logic [CNT_WIDTH-1:0]   ref_cnt [CH_NUM];
    logic [TW-1:0]          preset;
    logic [TW-1:0]          timer;
    logic [IW-1:0]          wr_idx;
    logic [CH_NUM-1:0]      sync1, sync2, sync3, edge_q;

    logic [GATE_WIDTH-1:0]  gate_eff;
    logic [TW-1:0]          preset_next;
    logic [TW-1:0]          two_p;
    logic                   all_closed;
    logic [2*CNT_WIDTH-1:0] sel_data;
    logic                   sel_vld;
    logic                   last_step;
    logic                   restart;
    logic                   start;

    // Edge pulse appears three clk_i cycles after the raw input edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= sig_clk_i;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    assign gate_eff    = (gate_time_i == '0) ? GATE_WIDTH'(1) : gate_time_i;
    assign preset_next = TW'(gate_eff) * TW'(GATE_TICKS);
    assign two_p       = {preset[TW-2:0], 1'b0};
    assign last_step   = (state == S_DUMP) && (wr_idx == IW'(CH_NUM));

`ifdef DFM_CONT_MEAS_EN
    assign restart = last_step && cont_i;
`else
    assign restart = 1'b0;
`endif
    assign start = ((state == S_IDLE) && gate_st_i) || restart;

    always_comb begin
        all_closed = 1'b1;
        sel_data   = '0;
        sel_vld    = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_st[i] != C_CLOSED)
                all_closed = 1'b0;
            // Channels still open at timeout are reported as zero data, invalid.
            if ((IW'(i) == wr_idx) && (ch_st[i] == C_CLOSED)) begin
                sel_data = {sig_cnt[i], ref_cnt[i]};
                sel_vld  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= S_IDLE;
            preset        <= '0;
            timer         <= '0;
            wr_idx        <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_ch_o   <= '0;
            reg_wr_data_o <= '0;
            reg_wr_vld_o  <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                ch_st[i]   <= C_WAIT;
                sig_cnt[i] <= '0;
                ref_cnt[i] <= '0;
            end
        end else begin
            done_o        <= 1'b0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_ch_o   <= '0;
            reg_wr_data_o <= '0;
            reg_wr_vld_o  <= 1'b0;
            case (state)
                S_RUN: begin
                    timer <= timer + TW'(1);
                    for (int i = 0; i < CH_NUM; i++) begin
                        case (ch_st[i])
                            C_WAIT: begin
                                if (edge_q[i])
                                    ch_st[i] <= C_COUNT;
                            end
                            C_COUNT: begin
                                if (ref_cnt[i] != '1)
                                    ref_cnt[i] <= ref_cnt[i] + CNT_WIDTH'(1);
                                if (edge_q[i]) begin
                                    if (sig_cnt[i] != '1)
                                        sig_cnt[i] <= sig_cnt[i] + CNT_WIDTH'(1);
                                    if (timer >= preset)
                                        ch_st[i] <= C_CLOSED;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (all_closed || (timer == two_p)) begin
                        state  <= S_DUMP;
                        wr_idx <= '0;
                    end
                end
                S_DUMP: begin
                    if (last_step) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        reg_wr_en_o   <= 1'b1;
                        reg_wr_ch_o   <= CHW'(wr_idx);
                        reg_wr_data_o <= sel_data;
                        reg_wr_vld_o  <= sel_vld;
                        wr_idx        <= wr_idx + IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (start) begin
                state  <= S_RUN;
                busy_o <= 1'b1;
                preset <= preset_next;
                timer  <= '0;
                wr_idx <= '0;
                for (int i = 0; i < CH_NUM; i++) begin
                    ch_st[i]   <= C_WAIT;
                    sig_cnt[i] <= '0;
                    ref_cnt[i] <= '0;
                end
            end
        end
    end

endmodule
